// File: rtl/traffic_light_param.sv
// Parametrised single-approach traffic-light controller.
// Green, then blinking green, then yellow, then red, then back to green.
// It also has a night flashing-yellow mode, a registered phase output and a
// pulse that marks each full red phase ending by timeout.
module traffic_light_param #(
    parameter int unsigned CW     = 12,
    parameter int unsigned G_CYC  = 1024,
    parameter int unsigned B_CYC  = 128,
    parameter int unsigned BLINKS = 2,
    parameter int unsigned Y_CYC  = 512,
    parameter int unsigned R_CYC  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pass,
    input  logic       night,
    output logic       R,
    output logic       G,
    output logic       Y,
    output logic [2:0] phase,
    output logic       cycle_done
);

    typedef enum logic [2:0] {
        StGreen  = 3'd0,
        StBoff   = 3'd1,
        StBon    = 3'd2,
        StYellow = 3'd3,
        StRed    = 3'd4,
        StNon    = 3'd5,
        StNoff   = 3'd6
    } state_e;

    // The blink index must hold values 0..BLINKS-1; keep at least one bit.
    localparam int unsigned BW = (BLINKS > 1) ? $clog2(BLINKS) : 1;

    // Each state leaves on the cycle where cnt reaches its last value (D-1).
    localparam logic [CW-1:0] GLast = CW'(G_CYC - 1);
    localparam logic [CW-1:0] BLast = CW'(B_CYC - 1);
    localparam logic [CW-1:0] YLast = CW'(Y_CYC - 1);
    localparam logic [CW-1:0] RLast = CW'(R_CYC - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bidx_q, bidx_d;
    logic          r_q, r_d;
    logic          g_q, g_d;
    logic          y_q, y_d;
    logic          cd_q, cd_d;
    logic          last;
    logic          in_night;

    // Timeout detection for the current state.
    always_comb begin
        last = 1'b0;
        unique case (state_q)
            StGreen:              last = (cnt_q == GLast);
            StBoff, StBon:        last = (cnt_q == BLast);
            StNon, StNoff:        last = (cnt_q == BLast);
            StYellow:             last = (cnt_q == YLast);
            StRed:                last = (cnt_q == RLast);
            default:              last = 1'b0;
        endcase
    end

    assign in_night = (state_q == StNon) || (state_q == StNoff);

    // Next state, counters and lamp decode.
    // Priority is night, then pass, then timeout, then counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bidx_d  = bidx_q;
        cd_d    = 1'b0;

        if (night) begin
            if (!in_night) begin
                state_d = StNon;
                cnt_d   = '0;
                bidx_d  = '0;
            end else if (last) begin
                state_d = (state_q == StNon) ? StNoff : StNon;
                cnt_d   = '0;
            end
        end else if (in_night) begin
            // Leaving night mode always goes through a full red.
            state_d = StRed;
            cnt_d   = '0;
            bidx_d  = '0;
        end else if (pass && (state_q != StGreen)) begin
            state_d = StGreen;
            cnt_d   = '0;
            bidx_d  = '0;
        end else if (last) begin
            cnt_d = '0;
            unique case (state_q)
                StGreen:  state_d = (BLINKS == 0) ? StYellow : StBoff;
                StBoff:   state_d = StBon;
                StBon: begin
                    if (32'(bidx_q) + 32'd1 >= BLINKS) begin
                        state_d = StYellow;
                        bidx_d  = '0;
                    end else begin
                        state_d = StBoff;
                        bidx_d  = bidx_q + BW'(1);
                    end
                end
                StYellow: state_d = StRed;
                StRed: begin
                    state_d = StGreen;
                    cd_d    = 1'b1;
                end
                default:  state_d = StGreen;
            endcase
        end

        // Lamps follow the next state so they change on the same edge.
        r_d = (state_d == StRed);
        g_d = (state_d == StGreen) || (state_d == StBon);
        y_d = (state_d == StYellow) || (state_d == StNon);
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StGreen;
            cnt_q   <= '0;
            bidx_q  <= '0;
            r_q     <= 1'b0;
            g_q     <= 1'b1;
            y_q     <= 1'b0;
            cd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            r_q     <= r_d;
            g_q     <= g_d;
            y_q     <= y_d;
            cd_q    <= cd_d;
        end
    end

    assign R          = r_q;
    assign G          = g_q;
    assign Y          = y_q;
    assign phase      = state_q;
    assign cycle_done = cd_q;

endmodule

// File: tb/tb_traffic_light_param.sv
// Scoreboard bench for traffic_light_param: a default-parameter instance and
// a small-parameter instance. The driver pushes expected outputs per edge; a
// negedge monitor pops and compares.
module tb_traffic_light_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, pass_a, night_a;
    logic       r_a, g_a, y_a, cd_a;
    logic [2:0] ph_a;

    logic       rst_b, pass_b, night_b;
    logic       r_b, g_b, y_b, cd_b;
    logic [2:0] ph_b;

    traffic_light_param u_dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .pass       (pass_a),
        .night      (night_a),
        .R          (r_a),
        .G          (g_a),
        .Y          (y_a),
        .phase      (ph_a),
        .cycle_done (cd_a)
    );

    traffic_light_param #(
        .CW     (3),
        .G_CYC  (4),
        .B_CYC  (1),
        .BLINKS (0),
        .Y_CYC  (2),
        .R_CYC  (3)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .pass       (pass_b),
        .night      (night_b),
        .R          (r_b),
        .G          (g_b),
        .Y          (y_b),
        .phase      (ph_b),
        .cycle_done (cd_b)
    );

    typedef struct {
        logic       sel;
        int         tag;
        int         t;
        logic [2:0] ph;
        logic       cd;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Default schedule: 1024 G, 128 off, 128 G, 128 off, 128 G, 512 Y, 1024 R.
    function automatic logic [2:0] ph_def(int t);
        int m;
        m = t % 3072;
        if (m < 1024) return 3'd0;
        if (m < 1152) return 3'd1;
        if (m < 1280) return 3'd2;
        if (m < 1408) return 3'd1;
        if (m < 1536) return 3'd2;
        if (m < 2048) return 3'd3;
        return 3'd4;
    endfunction

    // Small schedule: 4 G, 2 Y, 3 R.
    function automatic logic [2:0] ph_small(int t);
        int m;
        m = t % 9;
        if (m < 4) return 3'd0;
        if (m < 6) return 3'd3;
        return 3'd4;
    endfunction

    task automatic step(logic sel, int tag, int t, logic [2:0] ph, logic cd);
        exp_t e;
        @(posedge clk);
        e.sel = sel;
        e.tag = tag;
        e.t   = t;
        e.ph  = ph;
        e.cd  = cd;
        q.push_back(e);
        #1;
    endtask

    task automatic run_def(int tag, int t0, int t1);
        for (int t = t0; t <= t1; t++) begin
            step(1'b0, tag, t, ph_def(t), (t % 3072 == 0) && (t > 0));
        end
    endtask

    task automatic reset_a(int tag);
        rst_a   = 1'b0;
        pass_a  = 1'b0;
        night_a = 1'b0;
        repeat (3) step(1'b0, tag, 0, 3'd0, 1'b0);
        rst_a = 1'b1;
    endtask

    // Monitor: compare phase, lamp decode and cycle_done once per driven edge.
    exp_t       m_e;
    logic [2:0] m_ph;
    logic       m_r, m_g, m_y, m_cd, x_r, x_g, x_y;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e  = q.pop_front();
            m_ph = m_e.sel ? ph_b : ph_a;
            m_r  = m_e.sel ? r_b  : r_a;
            m_g  = m_e.sel ? g_b  : g_a;
            m_y  = m_e.sel ? y_b  : y_a;
            m_cd = m_e.sel ? cd_b : cd_a;
            x_r  = (m_e.ph == 3'd4);
            x_g  = (m_e.ph == 3'd0) || (m_e.ph == 3'd2);
            x_y  = (m_e.ph == 3'd3) || (m_e.ph == 3'd5);
            n_checks++;
            if (m_ph !== m_e.ph || m_r !== x_r || m_g !== x_g || m_y !== x_y
                || m_cd !== m_e.cd) begin
                n_fail++;
                $display("FAIL test%0d t=%0d: got phase=%0d R=%b G=%b Y=%b cd=%b, required phase=%0d R=%b G=%b Y=%b cd=%b",
                         m_e.tag, m_e.t, m_ph, m_r, m_g, m_y, m_cd,
                         m_e.ph, x_r, x_g, x_y, m_e.cd);
            end
        end
    end

    initial begin
        rst_a   = 1'b0;
        pass_a  = 1'b0;
        night_a = 1'b0;
        rst_b   = 1'b0;
        pass_b  = 1'b0;
        night_b = 1'b0;

        // 1: reset then free-run two full periods.
        reset_a(1);
        run_def(1, 1, 6200);

        // 2: pass pulse at YELLOW cnt=100 restarts a full green.
        reset_a(2);
        run_def(2, 1, 1636);
        pass_a = 1'b1;
        step(1'b0, 2, 0, 3'd0, 1'b0);
        pass_a = 1'b0;
        run_def(2, 1, 1600);

        // 3: pass held during GREEN has no effect.
        reset_a(3);
        for (int t = 1; t <= 1200; t++) begin
            pass_a = (t >= 200) && (t <= 900);
            step(1'b0, 3, t, ph_def(t), 1'b0);
        end
        pass_a = 1'b0;

        // 4: night during RED (with simultaneous pass), pass ignored, exit via full red.
        reset_a(4);
        run_def(4, 1, 2100);
        night_a = 1'b1;
        pass_a  = 1'b1;
        step(1'b0, 4, 0, 3'd5, 1'b0);
        for (int n = 1; n <= 600; n++) begin
            pass_a = (n == 130) || (n == 300) || (n == 455);
            step(1'b0, 4, n, ((n / 128) % 2 == 0) ? 3'd5 : 3'd6, 1'b0);
        end
        pass_a  = 1'b0;
        night_a = 1'b0;
        for (int r = 0; r <= 1023; r++) step(1'b0, 4, 10000 + r, 3'd4, 1'b0);
        step(1'b0, 4, 11024, 3'd0, 1'b1);
        for (int k = 1; k <= 20; k++) step(1'b0, 4, 11024 + k, 3'd0, 1'b0);

        // 5: reset at BON with pass and night asserted; reset wins.
        reset_a(5);
        run_def(5, 1, 1200);
        rst_a   = 1'b0;
        pass_a  = 1'b1;
        night_a = 1'b1;
        step(1'b0, 5, 0, 3'd0, 1'b0);
        rst_a   = 1'b1;
        pass_a  = 1'b0;
        night_a = 1'b0;
        run_def(5, 1, 1100);

        // 6: pass coinciding with RED timeout: green, no cycle_done.
        reset_a(6);
        run_def(6, 1, 3071);
        pass_a = 1'b1;
        step(1'b0, 6, 0, 3'd0, 1'b0);
        pass_a = 1'b0;
        run_def(6, 1, 50);

        // 7: small parameter set, period 9.
        rst_b = 1'b0;
        repeat (2) step(1'b1, 7, 0, 3'd0, 1'b0);
        rst_b = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            step(1'b1, 7, t, ph_small(t), (t % 9 == 0));
        end

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
